// File: rtl/alt_vipcti131_common_pkg.sv
// Shared definitions for the clocked-video-input common blocks:
// measurement state encoding and a saturating incrementer.
package alt_vipcti131_common_pkg;

  typedef enum logic {
    SEARCH  = 1'b0,
    MEASURE = 1'b1
  } state_e;

  // Returns v+1, clamped at max_v (callers zero-extend narrower counters).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/alt_vipcti131_common_edge_detect.sv
// Single-bit edge detector: registers the input and flags a rising
// (RISING=1) or falling (RISING=0) transition in the current cycle.
module alt_vipcti131_common_edge_detect #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sclr,
  input  logic sig_i,
  output logic pulse_o
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else if (sclr) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign pulse_o = RISING ? (sig_i & ~sig_q) : (~sig_i & sig_q);

endmodule

// File: rtl/alt_vipcti131_common_resolution_detect.sv
// Measures active samples per line and lines per frame, and reports a
// resolution only once it has repeated for STABLE_FRAMES good frames.
module alt_vipcti131_common_resolution_detect
  import alt_vipcti131_common_pkg::*;
#(
  parameter int SAMPLE_COUNT_WIDTH = 12,
  parameter int LINE_COUNT_WIDTH   = 12,
  parameter int STABLE_FRAMES      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sclr,
  input  logic                          de,
  input  logic                          vsync,
  input  logic                          count_sample,
  output logic [SAMPLE_COUNT_WIDTH-1:0] sample_width,
  output logic [LINE_COUNT_WIDTH-1:0]   line_height,
  output logic                          resolution_valid,
  output logic                          resolution_change,
  output logic                          overflow
);

  localparam int SCW = SAMPLE_COUNT_WIDTH;
  localparam int LCW = LINE_COUNT_WIDTH;
  localparam int STW = $clog2(STABLE_FRAMES + 1);
  localparam logic [31:0] SAMP_MAX   = 32'((64'd1 << SCW) - 64'd1);
  localparam logic [31:0] LINE_MAX   = 32'((64'd1 << LCW) - 64'd1);
  localparam logic [31:0] STABLE_MAX = 32'(STABLE_FRAMES);

  typedef struct packed {
    state_e           state;
    logic [SCW-1:0]   samp_cnt;
    logic [SCW-1:0]   frame_w;
    logic [SCW-1:0]   cand_w;
    logic [SCW-1:0]   sample_width;
    logic [LCW-1:0]   line_cnt;
    logic [LCW-1:0]   cand_h;
    logic [LCW-1:0]   line_height;
    logic [STW-1:0]   stable_cnt;
    logic             frame_ok;
    logic             first_line;
    logic             samp_sat;
    logic             line_sat;
    logic             skip_line;
    logic             valid;
    logic             change;
    logic             overflow;
  } regs_t;

  regs_t r_q, r_d;
  logic  line_end, frame_end, good;

  function automatic regs_t reset_regs();
    regs_t r;
    r            = '0;
    r.state      = SEARCH;
    r.frame_ok   = 1'b1;
    r.first_line = 1'b1;
    return r;
  endfunction

  // Start a fresh frame; a line still open at the boundary is dropped.
  function automatic regs_t arm(input regs_t r, input logic de_v);
    r.samp_cnt   = '0;
    r.line_cnt   = '0;
    r.frame_ok   = 1'b1;
    r.first_line = 1'b1;
    r.samp_sat   = 1'b0;
    r.line_sat   = 1'b0;
    r.skip_line  = de_v;
    return r;
  endfunction

  alt_vipcti131_common_edge_detect #(.RISING(1'b0)) u_de_edge (
    .clk    (clk),
    .rst    (rst),
    .sclr   (sclr),
    .sig_i  (de),
    .pulse_o(line_end)
  );

  alt_vipcti131_common_edge_detect #(.RISING(1'b1)) u_vsync_edge (
    .clk    (clk),
    .rst    (rst),
    .sclr   (sclr),
    .sig_i  (vsync),
    .pulse_o(frame_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= reset_regs();
    end else begin
      r_q <= r_d;
    end
  end

  always_comb begin
    r_d  = r_q;
    good = 1'b0;
    if (r_q.state == SEARCH) begin
      if (frame_end) begin
        r_d       = arm(r_q, de);
        r_d.state = MEASURE;
      end
    end else begin
      if (de && count_sample && !r_q.skip_line) begin
        if (&r_q.samp_cnt) begin
          r_d.samp_sat = 1'b1;
          r_d.overflow = 1'b1;
        end
        r_d.samp_cnt = SCW'(sat_inc(32'(r_q.samp_cnt), SAMP_MAX));
      end
      // Line closes before any same-cycle frame end so it counts toward that frame.
      if (line_end) begin
        if (!r_q.skip_line) begin
          if (r_q.first_line) begin
            r_d.frame_w = r_q.samp_cnt;
          end else if (r_q.samp_cnt != r_q.frame_w) begin
            r_d.frame_ok = 1'b0;
          end
          if (r_q.samp_sat) begin
            r_d.frame_ok = 1'b0;
          end
          if (&r_q.line_cnt) begin
            r_d.line_sat = 1'b1;
            r_d.overflow = 1'b1;
          end
          r_d.line_cnt   = LCW'(sat_inc(32'(r_q.line_cnt), LINE_MAX));
          r_d.first_line = 1'b0;
        end
        r_d.samp_cnt  = '0;
        r_d.samp_sat  = 1'b0;
        r_d.skip_line = 1'b0;
      end
      if (frame_end) begin
        good = r_d.frame_ok && (r_d.line_cnt != '0) && !r_d.line_sat;
        if (!good) begin
          r_d.stable_cnt = '0;
        end else if (r_d.frame_w == r_q.cand_w && r_d.line_cnt == r_q.cand_h) begin
          r_d.stable_cnt = STW'(sat_inc(32'(r_q.stable_cnt), STABLE_MAX));
        end else begin
          r_d.cand_w     = r_d.frame_w;
          r_d.cand_h     = r_d.line_cnt;
          r_d.stable_cnt = STW'(1);
        end
        if (r_d.stable_cnt == STW'(STABLE_FRAMES)) begin
          r_d.valid        = 1'b1;
          r_d.sample_width = r_d.cand_w;
          r_d.line_height  = r_d.cand_h;
        end else begin
          r_d.valid = 1'b0;
        end
        r_d = arm(r_d, de);
      end
    end
    r_d.change = (r_d.valid != r_q.valid) ||
                 (r_d.sample_width != r_q.sample_width) ||
                 (r_d.line_height != r_q.line_height);
    if (sclr) begin
      r_d = reset_regs();
    end
  end

  assign sample_width      = r_q.sample_width;
  assign line_height       = r_q.line_height;
  assign resolution_valid  = r_q.valid;
  assign resolution_change = r_q.change;
  assign overflow          = r_q.overflow;

endmodule

// File: tb/tb_alt_vipcti131_common_resolution_detect.sv
// Scoreboard bench: stimulus pushes the expected lock state for each frame
// end / sclr; a monitor pops and compares the cycle after the event.
module tb_alt_vipcti131_common_resolution_detect;

  typedef struct packed {
    logic        v;
    logic [11:0] w;
    logic [11:0] h;
    logic        c;
    logic        ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sclr_s = '0;
  logic [1:0] de_s = '0;
  logic [1:0] vs_s = '0;
  logic [1:0] cs_s = '0;
  logic [1:0] vs_q = '0;
  logic [1:0] ev = '0;

  logic [11:0] w_a, h_a, h_b;
  logic [3:0]  w_b;
  logic [1:0]  obs_v, obs_c, obs_ov;
  logic [11:0] obs_w [2];
  logic [11:0] obs_h [2];

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   failures = 0;
  int   n_ev [2] = '{0, 0};
  int   n_chg [2] = '{0, 0};

  always #5 clk = ~clk;

  alt_vipcti131_common_resolution_detect #(
    .SAMPLE_COUNT_WIDTH(12), .LINE_COUNT_WIDTH(12), .STABLE_FRAMES(2)
  ) dut_a (
    .clk(clk), .rst(rst), .sclr(sclr_s[0]), .de(de_s[0]), .vsync(vs_s[0]),
    .count_sample(cs_s[0]), .sample_width(w_a), .line_height(h_a),
    .resolution_valid(obs_v[0]), .resolution_change(obs_c[0]), .overflow(obs_ov[0])
  );

  alt_vipcti131_common_resolution_detect #(
    .SAMPLE_COUNT_WIDTH(4), .LINE_COUNT_WIDTH(12), .STABLE_FRAMES(2)
  ) dut_b (
    .clk(clk), .rst(rst), .sclr(sclr_s[1]), .de(de_s[1]), .vsync(vs_s[1]),
    .count_sample(cs_s[1]), .sample_width(w_b), .line_height(h_b),
    .resolution_valid(obs_v[1]), .resolution_change(obs_c[1]), .overflow(obs_ov[1])
  );

  assign obs_w[0] = w_a;
  assign obs_w[1] = {8'd0, w_b};
  assign obs_h[0] = h_a;
  assign obs_h[1] = h_b;

  function automatic exp_t mk(input logic v, input int w, input int h, input logic c, input logic ov);
    exp_t e;
    e.v  = v;
    e.w  = 12'(w);
    e.h  = 12'(h);
    e.c  = c;
    e.ov = ov;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic check_evt(input int d, input exp_t e);
    string tag;
    tag = $sformatf("dut%0d ev%0d", d, n_ev[d]);
    cmp({tag, " valid"},    32'(obs_v[d]),  32'(e.v));
    cmp({tag, " width"},    32'(obs_w[d]),  32'(e.w));
    cmp({tag, " height"},   32'(obs_h[d]),  32'(e.h));
    cmp({tag, " change"},   32'(obs_c[d]),  32'(e.c));
    cmp({tag, " overflow"}, 32'(obs_ov[d]), 32'(e.ov));
    $display("dut%0d event %0d: valid=%0d w=%0d h=%0d chg=%0d ovf=%0d", d, n_ev[d],
             obs_v[d], obs_w[d], obs_h[d], obs_c[d], obs_ov[d]);
    n_ev[d]++;
  endtask

  // Frame-end and sclr events, seen exactly as the DUT samples them.
  always @(posedge clk) begin
    vs_q <= vs_s;
    ev   <= (vs_s & ~vs_q) | sclr_s;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && obs_c[d]) n_chg[d]++;
    end
    if (ev[0]) begin
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut0 unexpected event: got empty queue expected entry");
      end else begin
        check_evt(0, q_a.pop_front());
      end
    end
    if (ev[1]) begin
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1 unexpected event: got empty queue expected entry");
      end else begin
        check_evt(1, q_b.pop_front());
      end
    end
  end

  task automatic push(input int d, input exp_t e);
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic drive(input int d, input logic de_v, input logic vs_v);
    @(negedge clk);
    de_s[d] = de_v;
    cs_s[d] = de_v;
    vs_s[d] = vs_v;
  endtask

  task automatic line(input int d, input int n);
    repeat (n) drive(d, 1'b1, 1'b0);
    repeat (3) drive(d, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse(input int d, input exp_t e);
    push(d, e);
    drive(d, 1'b0, 1'b1);
    drive(d, 1'b0, 1'b1);
    drive(d, 1'b0, 1'b0);
    drive(d, 1'b0, 1'b0);
  endtask

  // 8 lines of w samples; line 3 carries odd_w samples.
  task automatic frame(input int d, input int w, input int odd_w, input exp_t e);
    for (int l = 0; l < 8; l++) line(d, (l == 3) ? odd_w : w);
    vsync_pulse(d, e);
  endtask

  // Last line's de falls in the same cycle vsync rises.
  task automatic frame_coincide(input int d, input exp_t e);
    for (int l = 0; l < 7; l++) line(d, 16);
    repeat (16) drive(d, 1'b1, 1'b0);
    push(d, e);
    drive(d, 1'b0, 1'b1);
    drive(d, 1'b0, 1'b1);
    drive(d, 1'b0, 1'b0);
    drive(d, 1'b0, 1'b0);
  endtask

  task automatic sclr_pulse(input int d, input exp_t e);
    push(d, e);
    @(negedge clk);
    sclr_s[d] = 1'b1;
    @(negedge clk);
    sclr_s[d] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cmp($sformatf("dut%0d reset valid", d),    32'(obs_v[d]),  32'd0);
      cmp($sformatf("dut%0d reset width", d),    32'(obs_w[d]),  32'd0);
      cmp($sformatf("dut%0d reset height", d),   32'(obs_h[d]),  32'd0);
      cmp($sformatf("dut%0d reset change", d),   32'(obs_c[d]),  32'd0);
      cmp($sformatf("dut%0d reset overflow", d), 32'(obs_ov[d]), 32'd0);
    end

    // Acquire 16x8, switch to 20x8, back to 16x8, then a short line.
    frame(0, 16, 16, mk(0, 0, 0, 0, 0));
    frame(0, 16, 16, mk(0, 0, 0, 0, 0));
    frame(0, 16, 16, mk(1, 16, 8, 1, 0));
    frame(0, 20, 20, mk(0, 16, 8, 1, 0));
    frame(0, 20, 20, mk(1, 20, 8, 1, 0));
    frame(0, 20, 20, mk(1, 20, 8, 0, 0));
    frame(0, 16, 16, mk(0, 20, 8, 1, 0));
    frame(0, 16, 16, mk(1, 16, 8, 1, 0));
    frame(0, 16, 15, mk(0, 16, 8, 1, 0));
    frame(0, 16, 16, mk(0, 16, 8, 0, 0));
    frame(0, 16, 16, mk(1, 16, 8, 1, 0));

    // sclr mid-frame while locked; the rest of that frame is discarded.
    for (int l = 0; l < 3; l++) line(0, 16);
    sclr_pulse(0, mk(0, 0, 0, 0, 0));
    for (int l = 0; l < 5; l++) line(0, 16);
    vsync_pulse(0, mk(0, 0, 0, 0, 0));
    frame(0, 16, 16, mk(0, 0, 0, 0, 0));
    frame(0, 16, 16, mk(1, 16, 8, 1, 0));

    // Coincident line end / frame end keeps height at 8.
    frame_coincide(0, mk(1, 16, 8, 0, 0));
    frame_coincide(0, mk(1, 16, 8, 0, 0));

    // 4-bit sample counter: 20-sample lines overflow, 12-sample lines lock.
    frame(1, 20, 20, mk(0, 0, 0, 0, 0));
    frame(1, 20, 20, mk(0, 0, 0, 0, 1));
    frame(1, 20, 20, mk(0, 0, 0, 0, 1));
    frame(1, 12, 12, mk(0, 0, 0, 0, 1));
    frame(1, 12, 12, mk(1, 12, 8, 1, 1));
    sclr_pulse(1, mk(0, 0, 0, 0, 0));

    repeat (5) @(negedge clk);
    cmp("dut0 pending expectations", 32'(q_a.size()), 32'd0);
    cmp("dut1 pending expectations", 32'(q_b.size()), 32'd0);
    cmp("dut0 change pulses", 32'(n_chg[0]), 32'd8);
    cmp("dut1 change pulses", 32'(n_chg[1]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
